// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder.
// Holds the loader state encoding and the address-width helper.
package imem_pkg;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        LOAD,
        RUN
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    // Word-address width; at least one bit so a 1-word memory still indexes
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module imem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// UART-loaded instruction memory: header/word loader FSM plus fetch port.
// Holds the CPU in reset until a complete program has been received.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] curr_pc,
    output logic [31:0] instr_curr,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        load_start,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam int ADDR_W = addr_width(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [23:0] asm_q, asm_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              in_range;
    logic              pc_ok;

    assign in_range = (addr_q >> ADDR_W) == 16'h0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        asm_d    = asm_q;
        done_d   = 1'b0;
        err_d    = err_q;
        we       = 1'b0;
        wdata    = {rx_byte, asm_q};
        if (load_start) begin
            state_d  = HDR0;
            idx_d    = 2'd0;
            addr_d   = 16'h0;
            remain_d = 16'h0;
            asm_d    = 24'h0;
            err_d    = 1'b0;
        end else if (rx_valid) begin
            unique case (state_q)
                HDR0: begin
                    remain_d = {8'h00, rx_byte};
                    state_d  = HDR1;
                end
                HDR1: begin
                    remain_d = {rx_byte, remain_q[7:0]};
                    if ({rx_byte, remain_q[7:0]} == 16'h0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Out-of-range words are consumed but dropped
                        we       = in_range;
                        err_d    = err_q | ~in_range;
                        addr_d   = addr_q + 16'd1;
                        remain_d = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        asm_d[{idx_q, 3'b000} +: 8] = rx_byte;
                    end
                end
                RUN: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HDR0;
            idx_q    <= 2'd0;
            addr_q   <= 16'h0;
            remain_q <= 16'h0;
            asm_q    <= 24'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            asm_q    <= asm_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    imem_array #(
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (curr_pc[ADDR_W+1:2]),
        .rdata (rdata)
    );

    assign pc_ok = (state_q == RUN) && (curr_pc[1:0] == 2'b00)
                 && ((curr_pc >> (ADDR_W + 2)) == 32'h0);

    assign instr_curr = pc_ok ? rdata : NOP_INSTR;
    assign cpu_rst    = (state_q != RUN);
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: a 1024-word and a 4-word responder share stimulus
// and are compared against a word-level model of the program load.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_pc;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        load_start;

    logic [31:0] instr_a, instr_b;
    logic        cpu_rst_a, cpu_rst_b;
    logic        done_a, done_b;
    logic        err_a, err_b;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    logic [31:0] exp_a [1024];
    bit          val_a [1024];
    logic [31:0] exp_b [4];
    bit          val_b [4];
    logic [31:0] wq [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_a === 1'b1) done_seen++;
    end

    imem_responder #(.DEPTH_WORDS(1024)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .curr_pc    (curr_pc),
        .instr_curr (instr_a),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .load_start (load_start),
        .cpu_rst    (cpu_rst_a),
        .load_done  (done_a),
        .load_err   (err_a)
    );

    imem_responder #(.DEPTH_WORDS(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .curr_pc    (curr_pc),
        .instr_curr (instr_b),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .load_start (load_start),
        .cpu_rst    (cpu_rst_b),
        .load_done  (done_b),
        .load_err   (err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Loads every word in wq; the model updates from the word list alone
    task automatic run_load(input bit do_start);
        int          cnt = wq.size();
        logic [15:0] c16 = 16'(cnt);
        logic [31:0] w;
        int          seen0;
        bit          eb;
        if (do_start) pulse_start();
        tests++;
        if (cpu_rst_a !== 1'b1 || err_a !== 1'b0 || err_b !== 1'b0) begin
            fails++;
            $display("FAIL load_begin got rst=%b err=%b/%b exp rst=1 err=0/0",
                     cpu_rst_a, err_a, err_b);
        end
        send_byte(c16[7:0]);
        gap();
        seen0 = done_seen;
        send_byte(c16[15:8]);
        for (int i = 0; i < cnt; i++) begin
            w = wq[i];
            for (int b = 0; b < 4; b++) begin
                gap();
                seen0 = done_seen;
                if (i == cnt - 1 && b == 3) begin
                    tests++;
                    if (cpu_rst_a !== 1'b1 || done_a !== 1'b0) begin
                        fails++;
                        $display("FAIL pre_done got rst=%b done=%b exp 1 0",
                                 cpu_rst_a, done_a);
                    end
                end
                send_byte(w[8*b +: 8]);
            end
        end
        for (int i = 0; i < cnt; i++) begin
            if (i < 1024) begin exp_a[i] = wq[i]; val_a[i] = 1'b1; end
            if (i < 4)    begin exp_b[i] = wq[i]; val_b[i] = 1'b1; end
        end
        eb = (cnt > 4);
        tests++;
        if (done_a !== 1'b1 || done_b !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse cnt=%0d got %b%b exp 11", cnt, done_a, done_b);
        end
        tests++;
        if (cpu_rst_a !== 1'b0 || cpu_rst_b !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rst_fall got %b%b exp 00", cpu_rst_a, cpu_rst_b);
        end
        tests++;
        if (err_a !== 1'b0 || err_b !== eb) begin
            fails++;
            $display("FAIL load_err cnt=%0d got %b%b exp 0%b", cnt, err_a, err_b, eb);
        end
        tick();
        tests++;
        if (done_a !== 1'b0 || done_b !== 1'b0 || done_seen != seen0 + 1) begin
            fails++;
            $display("FAIL done_once got %b%b pulses=%0d exp 00 pulses=1",
                     done_a, done_b, done_seen - seen0);
        end
    endtask

    task automatic test_fetch_all();
        for (int i = 0; i < 1024; i++) begin
            if (val_a[i]) begin
                curr_pc = 32'(4 * i);
                #1;
                tests++;
                if (instr_a !== exp_a[i]) begin
                    fails++;
                    $display("FAIL fetch_a[%0d] got %h exp %h", i, instr_a, exp_a[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (val_b[i]) begin
                curr_pc = 32'(4 * i);
                #1;
                tests++;
                if (instr_b !== exp_b[i]) begin
                    fails++;
                    $display("FAIL fetch_b[%0d] got %h exp %h", i, instr_b, exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        load_start = 1'b0;
        curr_pc    = 32'h0;
        tick();
        tick();
        tests++;
        if (cpu_rst_a !== 1'b1 || cpu_rst_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_cpu_rst got %b%b exp 11", cpu_rst_a, cpu_rst_b);
        end
        tests++;
        if (done_a !== 1'b0 || err_a !== 1'b0 || err_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got done=%b err=%b%b exp 0 00",
                     done_a, err_a, err_b);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            curr_pc = {$urandom} & 32'hFFC;
            #1;
            tests++;
            if (instr_a !== NOP || instr_b !== NOP) begin
                fails++;
                $display("FAIL reset_instr pc=%h got %h %h exp %h",
                         curr_pc, instr_a, instr_b, NOP);
            end
        end
    endtask

    task automatic test_basic_load();
        wq = '{32'h0010_0513, 32'h0000_0073};
        run_load(1'b1);
        curr_pc = 32'h4;
        #1;
        tests++;
        if (instr_a !== 32'h0000_0073) begin
            fails++;
            $display("FAIL basic_pc4 got %h exp 00000073", instr_a);
        end
        test_fetch_all();
    endtask

    task automatic test_zero_count();
        wq.delete();
        run_load(1'b1);
        curr_pc = 32'h0;
        #1;
        tests++;
        if (instr_a !== 32'h0010_0513) begin
            fails++;
            $display("FAIL zero_nowrite got %h exp 00100513", instr_a);
        end
    endtask

    task automatic test_bad_pc();
        logic [31:0] pcs [4] = '{32'h2, 32'h1000, 32'h7, 32'hFFFF_FFFC};
        for (int k = 0; k < 4; k++) begin
            curr_pc = pcs[k];
            #1;
            tests++;
            if (instr_a !== NOP) begin
                fails++;
                $display("FAIL bad_pc_a pc=%h got %h exp %h", curr_pc, instr_a, NOP);
            end
        end
        curr_pc = 32'h10;
        #1;
        tests++;
        if (instr_b !== NOP) begin
            fails++;
            $display("FAIL bad_pc_b pc=%h got %h exp %h", curr_pc, instr_b, NOP);
        end
    endtask

    task automatic test_overflow();
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back($urandom);
        run_load(1'b1);
        tests++;
        if (err_b !== 1'b1) begin
            fails++;
            $display("FAIL overflow_err got %b exp 1", err_b);
        end
        test_fetch_all();
    endtask

    task automatic test_abort();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        gap();
        send_byte(8'h22);
        curr_pc = 32'h0;
        #1;
        tests++;
        if (cpu_rst_a !== 1'b1 || instr_a !== NOP) begin
            fails++;
            $display("FAIL abort_inload got rst=%b instr=%h exp 1 %h",
                     cpu_rst_a, instr_a, NOP);
        end
        wq = '{32'hDDCC_BBAA};
        run_load(1'b1);
        test_fetch_all();
    endtask

    task automatic test_start_vs_rx();
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_byte    = 8'h05;
        tick();
        load_start = 1'b0;
        rx_valid   = 1'b0;
        wq = '{$urandom};
        run_load(1'b0);
        test_fetch_all();
    endtask

    task automatic test_reset_midload();
        logic [31:0] w0 = $urandom;
        logic [31:0] w1 = $urandom;
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8]);
        send_byte(w1[7:0]);
        exp_a[0] = w0; val_a[0] = 1'b1;
        exp_b[0] = w0; val_b[0] = 1'b1;
        rst = 1'b1;
        #1;
        tests++;
        if (cpu_rst_a !== 1'b1 || done_a !== 1'b0 || instr_a !== NOP) begin
            fails++;
            $display("FAIL midload_rst got rst=%b done=%b instr=%h exp 1 0 %h",
                     cpu_rst_a, done_a, instr_a, NOP);
        end
        tick();
        rst = 1'b0;
        wq = '{$urandom};
        run_load(1'b0);
        test_fetch_all();
    endtask

    task automatic test_rx_in_run();
        for (int k = 0; k < 8; k++) begin
            send_byte(8'($urandom));
            tests++;
            if (cpu_rst_a !== 1'b0 || done_a !== 1'b0) begin
                fails++;
                $display("FAIL run_ignore_rx got rst=%b done=%b exp 0 0",
                         cpu_rst_a, done_a);
            end
        end
        test_fetch_all();
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 4; r++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
                wq.push_back($urandom);
            end
            run_load(1'b1);
            test_fetch_all();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) val_a[i] = 1'b0;
        for (int i = 0; i < 4; i++) val_b[i] = 1'b0;
        test_reset();
        test_basic_load();
        test_zero_count();
        test_bad_pc();
        test_overflow();
        test_abort();
        test_start_vs_rx();
        test_reset_midload();
        test_rx_in_run();
        test_random_loads();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: instruction storage depth in 32-bit words, power of two.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: word returned whenever no valid instruction is served.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port curr_pc, input, 32: byte address issued by the fetch stage.
REQ-006 SHALL have port instr_curr, output, 32: instruction returned to fetch in the same cycle (combinational read).
REQ-007 SHALL have port rx_byte, input, 8: program-load byte from the UART receiver.
REQ-008 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_byte.
REQ-009 SHALL have port load_start, input, 1: one-cycle request to begin a new program load.
REQ-010 SHALL have port cpu_rst, output, 1: hold-in-reset for the CPU core, high while not in RUN.
REQ-011 SHALL have port load_done, output, 1: one-cycle pulse on load completion.
REQ-012 SHALL have port load_err, output, 1: sticky overflow flag, cleared by load_start or rst.

Function
REQ-013 SHALL implement states HDR0, HDR1, LOAD and RUN.
REQ-014 SHALL, in HDR0, capture rx_byte on rx_valid as word-count bits [7:0], then go to HDR1.
REQ-015 SHALL, in HDR1, capture rx_byte on rx_valid as word-count bits [15:8], then go to LOAD, or to RUN with load_done pulsed if the count is 0.
REQ-016 SHALL, in LOAD, assemble 4 rx_valid bytes little-endian: first byte goes to bits [7:0], fourth byte to bits [31:24].
REQ-017 SHALL, on the fourth byte, write the assembled word at the word-address counter (starting at 0), increment the counter and decrement the remaining count in the same cycle.
REQ-018 SHALL, when the remaining count reaches 0 on a write, go to RUN and assert load_done for exactly that following cycle.
REQ-019 SHALL, for words at address >= DEPTH_WORDS, not perform the write, still consume the bytes, and set load_err.
REQ-020 SHALL drive cpu_rst = 1 in HDR0, HDR1 and LOAD, and 0 only in RUN; cpu_rst SHALL fall on the same edge load_done rises.
REQ-021 SHALL, in RUN, drive instr_curr = mem[curr_pc[ADDR_W+1:2]] when curr_pc[1:0]==0 and curr_pc < 4*DEPTH_WORDS.
REQ-022 SHALL drive instr_curr = NOP_INSTR otherwise: misaligned PC, out-of-range PC, or any non-RUN state.
REQ-023 SHALL ignore rx_valid in RUN.
REQ-024 SHALL, on load_start in any state, go to HDR0 and clear the byte index, word address, remaining count and load_err.
REQ-025 SHALL, when load_start and rx_valid coincide, let load_start win and drop the byte.
REQ-026 SHALL not apply a partial word (fewer than 4 bytes received) to memory when aborted by load_start.
REQ-027 SHALL use a 16-bit word count; a count of 0xFFFF SHALL be legal, with overflow handled per REQ-019.

Reset
REQ-028 SHALL, on rst, enter HDR0 with cpu_rst=1, load_done=0, load_err=0, instr_curr=NOP_INSTR, and all counters cleared.
REQ-029 SHALL not reset memory contents; content is undefined until written.
REQ-030 SHALL, on rst asserted mid-load, abandon the load immediately and return to HDR0.

Structure
REQ-031 SHALL take the state enum, NOP_INSTR default and ADDR_W derivation (log2 DEPTH_WORDS) from shared package imem_pkg.
REQ-032 SHALL place storage in a sub-module imem_array: one synchronous write port and one asynchronous read port, no reset.

Verification
REQ-033 SHALL cover basic load: bytes 02 00, 13 05 10 00, 73 00 00 00 -> mem[0]=32'h00100513, mem[1]=32'h00000073; load_done pulses once; cpu_rst falls; curr_pc=4 returns 32'h00000073.
REQ-034 SHALL cover zero count: bytes 00 00 -> RUN on the cycle after the second byte, load_done=1, no write.
REQ-035 SHALL cover bad fetch addresses: in RUN, curr_pc=32'h2 and curr_pc=32'h1000 (DEPTH_WORDS=1024) -> instr_curr=32'h00000013.
REQ-036 SHALL cover overflow with DEPTH_WORDS=4: count 5 with 20 data bytes -> mem[0..3] written, load_err=1, load_done pulses, RUN entered.
REQ-037 SHALL cover abort: load_start after 2 data bytes of word 0, then load of count 1 with AA BB CC DD -> mem[0]=32'hDDCCBBAA, load_err=0.
REQ-038 SHALL cover mid-load reset: rst pulsed during LOAD -> cpu_rst=1, state HDR0, next two bytes taken as a header.
